parking_gate_controller: RTL and testbench
==========================================

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter CAPACITY, default 15, SHALL set the maximum number of occupied slots (1..15).
REQ-002 Parameter OPEN_CYCLES, default 8, SHALL set the number of cycles a gate stays open waiting for a car to pass (1..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 entry_req  input  1  level; a car is waiting at the entry loop.
REQ-006 exit_req  input  1  level; a car is waiting at the exit loop.
REQ-007 entry_pass  input  1  level; a car is crossing the entry beam behind the barrier.
REQ-008 exit_pass  input  1  level; a car is crossing the exit beam behind the barrier.
REQ-009 entry_open  output  1  the entry barrier is open.
REQ-010 exit_open  output  1  the exit barrier is open.
REQ-011 count  output  4  occupied-slot count; this port feeds the existing Seven_Segment decoder unchanged.
REQ-012 full  output  1  high when count == CAPACITY.
REQ-013 alarm  output  1  one-cycle pulse flagging a pass without an open gate.

Function
REQ-014 Each gate SHALL run the FSM IDLE -> OPEN -> CLOSED -> IDLE, with a gate_open output high only in OPEN.
REQ-015 IDLE->OPEN: the gate SHALL open when req=1 and admission is allowed; the open output is high in the cycle after req is sampled.
REQ-016 Entry admission SHALL be allowed only if count < CAPACITY; exit admission only if count != 0.
REQ-017 OPEN->CLOSED: on the first cycle pass=1 (commit), or after OPEN_CYCLES cycles in OPEN with no pass (timeout, no commit).
REQ-018 CLOSED->IDLE: only when req=0, so one request opens the gate at most once.
REQ-019 Entry commit SHALL increment count; exit commit SHALL decrement count; both become visible in the cycle after pass is sampled, and the gate closes in that same cycle.
REQ-020 An entry commit and an exit commit in the same cycle SHALL leave count unchanged.
REQ-021 count SHALL never exceed CAPACITY or wrap below 0; an update that would do so SHALL be dropped and SHALL pulse alarm.
REQ-022 A pass=1 on a gate not in OPEN SHALL be ignored for counting and SHALL pulse alarm for 1 cycle per rising edge of that pass.
REQ-023 A pass that stays high for several cycles in OPEN SHALL commit exactly once.
REQ-024 full SHALL be combinational from the registered count.
REQ-025 Both gates SHALL operate concurrently and independently, apart from sharing count.
REQ-026 While the entry gate is OPEN, a second entry admission SHALL NOT occur.
REQ-027 A rise of full while the entry gate is already OPEN SHALL NOT close that gate.

Reset
REQ-028 With rst=1, both FSMs SHALL go to IDLE, and count, entry_open, exit_open and alarm SHALL be 0 on the next edge, overriding any same-cycle pass or req.
REQ-029 Reset asserted mid-OPEN SHALL close the gate on the next edge, with no commit.

Structure
REQ-030 A shared package SHALL hold the gate state enum (IDLE, OPEN, CLOSED) and the default CAPACITY and OPEN_CYCLES constants.
REQ-031 A sub-module gate_fsm SHALL contain:
- the per-gate FSM;
- the timeout counter;
- pass edge detection.
REQ-032 gate_fsm SHALL be instantiated twice (entry, exit) and SHALL emit a one-cycle commit pulse and an alarm pulse.
REQ-033 The top SHALL own count and full, and OR the alarm pulses.

Verification
REQ-034 Reset, then entry_req=1, then entry_pass=1 for 3 cycles -> entry_open=1 one cycle after req, count=1 once, gate closed the cycle after the pass rises.
REQ-035 15 entry sequences with CAPACITY=15 -> count=15, full=1; a 16th entry_req -> entry_open stays 0 and count stays 15.
REQ-036 Simultaneous entry and exit commits at count=5 -> count stays 5 and alarm=0.
REQ-037 entry_req=1 with no pass and OPEN_CYCLES=8 -> entry_open high for 8 cycles, then 0, count unchanged; gate does not reopen until req drops and rises again.
REQ-038 Tailgate: exit_pass pulse while exit_open=0 at count=3 -> alarm high for 1 cycle, count stays 3.
REQ-039 rst=1 during OPEN with entry_pass=1 in the same cycle -> next cycle entry_open=0, count=0, alarm=0.

Source files
------------

// File: rtl/parking_gate_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller_pkg
// Description : Gate state encoding and default sizing shared by the gate
//               controller and its per-gate FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_gate_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        CLOSED = 2'd2
    } gate_state_t;

    localparam int c_capacity_default    = 15;
    localparam int c_open_cycles_default = 8;

endpackage : parking_gate_controller_pkg
`default_nettype wire

// File: rtl/parking_gate_controller_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module      : gate_fsm
// Description : One barrier: IDLE/OPEN/CLOSED sequencing, open timeout and
//               pass edge detection; emits commit and alarm pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_fsm
    import parking_gate_controller_pkg::*;
#(
    parameter int OPEN_CYCLES = c_open_cycles_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_allow,
    input  logic i_pass,
    output logic o_open,
    output logic o_commit,
    output logic o_alarm
);

    localparam logic [7:0] c_last_tick = 8'(OPEN_CYCLES - 1);

    gate_state_t r_state;
    logic        r_open;
    logic [7:0]  r_timer;
    logic        r_pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_open   <= 1'b0;
            r_timer  <= 8'd0;
            r_pass_d <= 1'b0;
        end else begin
            r_pass_d <= i_pass;
            case (r_state)
                IDLE: begin
                    if (i_req && i_allow) begin
                        r_state <= OPEN;
                        r_open  <= 1'b1;
                        r_timer <= 8'd0;
                    end
                end
                OPEN: begin
                    if (i_pass || (r_timer == c_last_tick)) begin
                        r_state <= CLOSED;
                        r_open  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                CLOSED: begin
                    // Stay shut until the requester leaves the loop.
                    if (!i_req) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_open  <= 1'b0;
                end
            endcase
        end
    end

    assign o_open   = r_open;
    assign o_commit = (r_state == OPEN) && i_pass;
    assign o_alarm  = i_pass && !r_pass_d && (r_state != OPEN);

endmodule : gate_fsm
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_controller
// Description : Entry/exit barrier pair sharing one occupied-slot counter.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_controller
    import parking_gate_controller_pkg::*;
#(
    parameter int CAPACITY    = c_capacity_default,
    parameter int OPEN_CYCLES = c_open_cycles_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       entry_pass,
    input  logic       exit_pass,
    output logic       entry_open,
    output logic       exit_open,
    output logic [3:0] count,
    output logic       full,
    output logic       alarm
);

    localparam logic [3:0] c_capacity = 4'(CAPACITY);

    logic [3:0] r_count;
    logic       r_alarm;
    logic       w_entry_commit, w_exit_commit;
    logic       w_entry_alarm, w_exit_alarm;
    logic       w_inc, w_dec, w_bound_err;

    gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .i_req    (entry_req),
        .i_allow  (r_count < c_capacity),
        .i_pass   (entry_pass),
        .o_open   (entry_open),
        .o_commit (w_entry_commit),
        .o_alarm  (w_entry_alarm)
    );

    gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES)) u_exit (
        .clk      (clk),
        .rst      (rst),
        .i_req    (exit_req),
        .i_allow  (r_count != 4'd0),
        .i_pass   (exit_pass),
        .o_open   (exit_open),
        .o_commit (w_exit_commit),
        .o_alarm  (w_exit_alarm)
    );

    // Simultaneous commits cancel, so only a lone commit can hit a bound.
    assign w_inc       = w_entry_commit && !w_exit_commit;
    assign w_dec       = w_exit_commit && !w_entry_commit;
    assign w_bound_err = (w_inc && (r_count >= c_capacity)) ||
                         (w_dec && (r_count == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_entry_alarm || w_exit_alarm || w_bound_err;
            if (!w_bound_err) begin
                if (w_inc) begin
                    r_count <= r_count + 4'd1;
                end else if (w_dec) begin
                    r_count <= r_count - 4'd1;
                end
            end
        end
    end

    assign count = r_count;
    assign full  = (r_count == c_capacity);
    assign alarm = r_alarm;

endmodule : parking_gate_controller
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_controller
// Description : Directed scenarios plus randomized traffic against a
//               behavioural car-park model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

    localparam int c_cap = 15;
    localparam int c_oc  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0, exit_req = 1'b0;
    logic       entry_pass = 1'b0, exit_pass = 1'b0;
    logic       entry_open, exit_open, full, alarm;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: index 0 = entry gate, 1 = exit gate.
    int m_count;
    bit m_alarm;
    bit m_open [2];
    bit m_wait [2];
    bit m_prev [2];
    int m_left [2];

    parking_gate_controller #(.CAPACITY(c_cap), .OPEN_CYCLES(c_oc)) dut (
        .clk        (clk),
        .rst        (rst),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .entry_pass (entry_pass),
        .exit_pass  (exit_pass),
        .entry_open (entry_open),
        .exit_open  (exit_open),
        .count      (count),
        .full       (full),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic model_step;
        bit req [2];
        bit pas [2];
        bit cm  [2];
        bit al;
        int nxt;
        req[0] = entry_req; req[1] = exit_req;
        pas[0] = entry_pass; pas[1] = exit_pass;
        if (rst) begin
            m_count = 0;
            m_alarm = 0;
            for (int g = 0; g < 2; g++) begin
                m_open[g] = 0; m_wait[g] = 0; m_prev[g] = 0; m_left[g] = 0;
            end
            return;
        end
        al = 0;
        for (int g = 0; g < 2; g++) begin
            cm[g] = 0;
            if (m_open[g]) begin
                if (pas[g]) begin
                    cm[g] = 1; m_open[g] = 0; m_wait[g] = 1;
                end else if (m_left[g] == 1) begin
                    m_open[g] = 0; m_wait[g] = 1;
                end else begin
                    m_left[g]--;
                end
            end else begin
                if (pas[g] && !m_prev[g]) al = 1;
                if (m_wait[g]) begin
                    if (!req[g]) m_wait[g] = 0;
                end else if (req[g] && ((g == 0) ? (m_count < c_cap) : (m_count > 0))) begin
                    m_open[g] = 1; m_left[g] = c_oc;
                end
            end
            m_prev[g] = pas[g];
        end
        nxt = m_count + int'(cm[0]) - int'(cm[1]);
        if (nxt > c_cap || nxt < 0) al = 1;
        else m_count = nxt;
        m_alarm = al;
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic entry_cycle;
        entry_req = 1; tick();
        entry_pass = 1; tick();
        entry_req = 0; entry_pass = 0; tick();
    endtask

    task automatic exit_cycle;
        exit_req = 1; tick();
        exit_pass = 1; tick();
        exit_req = 0; exit_pass = 0; tick();
    endtask

    task automatic test_reset;
        rst = 1; tick(); tick();
        n_checks++;
        if (count !== 4'd0 || entry_open !== 1'b0 || exit_open !== 1'b0 ||
            alarm !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: count=%0d eo=%b xo=%b alarm=%b full=%b, required 0 0 0 0 0",
                     count, entry_open, exit_open, alarm, full);
        end
        rst = 0; tick();
    endtask

    task automatic test_entry_pass;
        entry_req = 1; tick();
        n_checks++;
        if (entry_open !== 1'b1) begin
            n_fail++; $display("FAIL entry_open_latency: got %b, required 1", entry_open);
        end
        entry_pass = 1; tick();
        n_checks++;
        if (count !== 4'd1 || entry_open !== 1'b0) begin
            n_fail++; $display("FAIL entry_commit: count=%0d open=%b, required 1 0", count, entry_open);
        end
        tick(); tick();
        n_checks++;
        if (count !== 4'd1 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL entry_single_commit: count=%0d alarm=%b, required 1 0", count, alarm);
        end
        entry_req = 0; entry_pass = 0; tick();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 14; i++) entry_cycle();
        n_checks++;
        if (count !== 4'd15 || full !== 1'b1) begin
            n_fail++; $display("FAIL fill: count=%0d full=%b, required 15 1", count, full);
        end
        entry_req = 1; tick(); tick();
        n_checks++;
        if (entry_open !== 1'b0 || count !== 4'd15) begin
            n_fail++; $display("FAIL full_reject: open=%b count=%0d, required 0 15", entry_open, count);
        end
        entry_req = 0; tick();
        for (int i = 0; i < 10; i++) exit_cycle();
        n_checks++;
        if (count !== 4'd5 || full !== 1'b0) begin
            n_fail++; $display("FAIL drain: count=%0d full=%b, required 5 0", count, full);
        end
    endtask

    task automatic test_simultaneous;
        entry_req = 1; exit_req = 1; tick();
        n_checks++;
        if (entry_open !== 1'b1 || exit_open !== 1'b1) begin
            n_fail++; $display("FAIL both_open: eo=%b xo=%b, required 1 1", entry_open, exit_open);
        end
        entry_pass = 1; exit_pass = 1; tick();
        n_checks++;
        if (count !== 4'd5 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL simultaneous: count=%0d alarm=%b, required 5 0", count, alarm);
        end
        entry_req = 0; exit_req = 0; entry_pass = 0; exit_pass = 0; tick();
    endtask

    task automatic test_timeout;
        int open_cycles = 0;
        entry_req = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (entry_open === 1'b1) open_cycles++;
        end
        n_checks++;
        if (open_cycles != c_oc || entry_open !== 1'b0 || count !== 4'd5) begin
            n_fail++;
            $display("FAIL timeout: open_cycles=%0d open=%b count=%0d, required %0d 0 5",
                     open_cycles, entry_open, count, c_oc);
        end
        entry_req = 0; tick();
        entry_req = 1; tick();
        n_checks++;
        if (entry_open !== 1'b1) begin
            n_fail++; $display("FAIL reopen: got %b, required 1", entry_open);
        end
        entry_pass = 1; tick();
        entry_req = 0; entry_pass = 0; tick();
        for (int i = 0; i < 3; i++) exit_cycle();
    endtask

    task automatic test_tailgate;
        exit_pass = 1; tick();
        n_checks++;
        if (alarm !== 1'b1 || count !== 4'd3) begin
            n_fail++; $display("FAIL tailgate: alarm=%b count=%0d, required 1 3", alarm, count);
        end
        tick();
        n_checks++;
        if (alarm !== 1'b0 || exit_open !== 1'b0) begin
            n_fail++; $display("FAIL tailgate_pulse: alarm=%b open=%b, required 0 0", alarm, exit_open);
        end
        exit_pass = 0; tick();
    endtask

    task automatic test_reset_open;
        entry_req = 1; tick();
        rst = 1; entry_pass = 1; tick();
        n_checks++;
        if (entry_open !== 1'b0 || count !== 4'd0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_open: open=%b count=%0d alarm=%b, required 0 0 0",
                     entry_open, count, alarm);
        end
        rst = 0; entry_req = 0; entry_pass = 0; tick();
    endtask

    task automatic test_random;
        int errs = 0;
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) entry_req = ~entry_req;
            if ($urandom_range(0, 7) == 0) exit_req  = ~exit_req;
            entry_pass = ($urandom_range(0, 4) == 0);
            exit_pass  = ($urandom_range(0, 4) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (entry_open !== m_open[0] || exit_open !== m_open[1] ||
                count !== 4'(m_count) || alarm !== m_alarm || full !== (m_count == c_cap)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: eo=%b xo=%b count=%0d alarm=%b full=%b, required %b %b %0d %b %b",
                             i, entry_open, exit_open, count, alarm, full,
                             m_open[0], m_open[1], m_count, m_alarm, (m_count == c_cap));
            end
        end
        rst = 0; entry_req = 0; exit_req = 0; entry_pass = 0; exit_pass = 0; tick();
    endtask

    initial begin
        test_reset();
        test_entry_pass();
        test_fill();
        test_simultaneous();
        test_timeout();
        test_tailgate();
        test_reset_open();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_parking_gate_controller
`default_nettype wire
